// File: rtl/count_seg_display_pkg.sv
// Shared constants for the count display: segment patterns and digit-scan states.
package count_seg_display_pkg;

   localparam int unsigned CNT_W = 4;
   localparam int unsigned SEG_W = 7;
   localparam int unsigned DIG_W = 2;

   // Active-high segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
   localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
   localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
   localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
   localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
   localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
   localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
   localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
   localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
   localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
   localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

   // Digit slot currently being driven
   typedef enum logic {
      ST_ONES = 1'b0,
      ST_TENS = 1'b1
   } dstate_e;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD digit to active-high 7-segment pattern; 10..15 render blank.
module seg7_decode
   import count_seg_display_pkg::*;
(
   input  logic [CNT_W-1:0] digit,
   output logic [SEG_W-1:0] pattern
);

   // Digit lookup
   always_comb begin
      pattern = SEG_BLANK;
      case (digit)
         4'd0:    pattern = SEG_0;
         4'd1:    pattern = SEG_1;
         4'd2:    pattern = SEG_2;
         4'd3:    pattern = SEG_3;
         4'd4:    pattern = SEG_4;
         4'd5:    pattern = SEG_5;
         4'd6:    pattern = SEG_6;
         4'd7:    pattern = SEG_7;
         4'd8:    pattern = SEG_8;
         4'd9:    pattern = SEG_9;
         default: pattern = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/count_seg_display.sv
// Resynchronises a 4-bit ripple count and scans it as two decimal digits
// onto a multiplexed 7-segment display; pulses changed on each new value.
module count_seg_display
   import count_seg_display_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 50000,
   parameter bit          SEG_ACTIVE_LOW = 1'b1,
   parameter bit          DIG_ACTIVE_LOW = 1'b1
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             q0,
   input  logic             q1,
   input  logic             q2,
   input  logic             q3,
   output logic [SEG_W-1:0] seg,
   output logic             dp,
   output logic [DIG_W-1:0] an,
   output logic             changed
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PW-1:0]    PMAX    = PW'(SCAN_DIV - 1);
   localparam logic [SEG_W-1:0] SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic [DIG_W-1:0] AN_OFF  = DIG_ACTIVE_LOW ? 2'b11 : 2'b00;
   localparam logic             DP_OFF  = SEG_ACTIVE_LOW;

   logic [CNT_W-1:0] sync1, sync2, v;
   logic [PW-1:0]    pcnt;
   logic             tick;
   dstate_e          state, state_nxt;
   logic             tens;
   logic [CNT_W-1:0] ones;
   logic [CNT_W-1:0] digit;
   logic [SEG_W-1:0] pat;
   logic [DIG_W-1:0] an_ah;

   // Two-flop synchroniser, capture register and change detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1   <= '0;
         sync2   <= '0;
         v       <= '0;
         changed <= 1'b0;
      end else begin
         sync1   <= {q3, q2, q1, q0};
         sync2   <= sync1;
         v       <= sync2;
         changed <= (sync2 != v);
      end
   end

   // Decimal split of the captured value (0..15)
   always_comb begin
      tens = (v >= 4'd10);
      ones = tens ? (v - 4'd10) : v;
   end

   // Scan prescaler, wraps at SCAN_DIV-1
   assign tick = (pcnt == PMAX);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    pcnt <= '0;
      else if (tick) pcnt <= '0;
      else           pcnt <= pcnt + PW'(1);
   end

   // Digit state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_ONES;
      else        state <= state_nxt;
   end

   // Next state and active-high digit select / digit value for the current slot
   always_comb begin
      state_nxt = state;
      an_ah     = 2'b01;
      digit     = ones;
      if (tick) state_nxt = (state == ST_ONES) ? ST_TENS : ST_ONES;
      if (state == ST_TENS) begin
         an_ah = 2'b10;
         digit = tens ? 4'd1 : 4'hF;   // 4'hF decodes to blank: leading-zero suppression
      end
   end

   seg7_decode u_dec (
      .digit   (digit),
      .pattern (pat)
   );

   // Output register with polarity applied
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg <= SEG_OFF;
         an  <= AN_OFF;
         dp  <= DP_OFF;
      end else begin
         seg <= SEG_ACTIVE_LOW ? ~pat : pat;
         an  <= DIG_ACTIVE_LOW ? ~an_ah : an_ah;
         dp  <= DP_OFF;
      end
   end

endmodule
